uart_cmd_slave: RTL and testbench

//  DUT-side end of the host UART command link; the counterpart of UART_comm_mstr.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_core.sv | 120 ++++++++++++
 rtl/uart_cmd_slave.sv | 183 ++++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the host UART command link.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int CMD_BYTES  = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop RX synchroniser plus start/data/stop FSM, one byte per frame.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  // prev_q lets IDLE react only to a real 1->0 edge, not a line left low by a bad stop bit
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        if (prev_q && !sync2_q) state_d = RX_START;
        else                    state_d = RX_IDLE;
      end
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               state_d = RX_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            vld_d  = 1'b1;
            byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State register; synchroniser presets to line-idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_vld    = vld_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_cmd_slave.sv
// Host UART command slave: frames three RX bytes into a 24-bit command and
// serialises 8-bit responses on TX; RX and TX run fully independently.
module uart_cmd_slave
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PEN  = CW'(BAUD_DIV - 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [1:0]    LAST_BYTE = 2'(CMD_BYTES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  logic [7:0] rx_byte_s;
  logic       rx_vld_s;
  logic       rx_ferr_s;
  logic       rx_busy_s;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RX),
    .rx_byte   (rx_byte_s),
    .rx_vld    (rx_vld_s),
    .frame_err (rx_ferr_s),
    .rx_busy   (rx_busy_s)
  );

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [23:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Framer: partial bytes are staged so cmd stays stable until the third byte lands
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    if (rx_busy_s || (byte_cnt_q == 2'd0)) tmo_d = '0;
    else if (tmo_q != TMO_MAX)             tmo_d = tmo_q + TMO_ONE;
    else                                   tmo_d = tmo_q;
    if (rx_vld_s) begin
      case (byte_cnt_q)
        2'd0: begin
          b0_d       = rx_byte_s;
          byte_cnt_d = 2'd1;
        end
        2'd1: begin
          b1_d       = rx_byte_s;
          byte_cnt_d = 2'd2;
        end
        LAST_BYTE: begin
          cmd_d      = {b0_q, b1_q, rx_byte_s};
          cmd_rdy_d  = 1'b1;
          byte_cnt_d = 2'd0;
        end
        default: byte_cnt_d = 2'd0;
      endcase
    end else if (rx_ferr_s) begin
      byte_cnt_d = 2'd0;
    end else if ((tmo_q == TMO_MAX) && (byte_cnt_q != 2'd0)) begin
      byte_cnt_d = 2'd0;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  tx_state_e             tx_state_q, tx_state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CW-1:0]         tx_baud_q, tx_baud_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic                  tx_q, tx_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  resp_sent_q, resp_sent_d;

  // Transmitter: tx_q always holds the bit currently on the line; frame shifts right
  always_comb begin
    tx_state_d  = tx_state_q;
    frame_d     = frame_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_state_d = TX_XMIT;
          frame_d    = {1'b1, resp, 1'b0};
          tx_baud_d  = '0;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end else begin
          tx_d      = 1'b1;
          tx_busy_d = 1'b0;
        end
      end
      TX_XMIT: begin
        resp_sent_d = (tx_bit_q == LAST_BIT) && (tx_baud_q == BAUD_PEN);
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            tx_busy_d  = 1'b0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            frame_d  = {1'b1, frame_q[FRAME_BITS-1:1]};
            tx_d     = frame_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State registers for framer and transmitter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q  <= 2'd0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      cmd_q       <= 24'h000000;
      cmd_rdy_q   <= 1'b0;
      tmo_q       <= '0;
      tx_state_q  <= TX_IDLE;
      frame_q     <= {FRAME_BITS{1'b1}};
      tx_baud_q   <= '0;
      tx_bit_q    <= 4'd0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tmo_q       <= tmo_d;
      tx_state_q  <= tx_state_d;
      frame_q     <= frame_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;
  assign tx_busy   = tx_busy_q;
  assign frame_err = rx_ferr_s;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave with BAUD_DIV=16, TIMEOUT=1024.
module tb_uart_cmd_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int rise_cnt = 0;
  int fe_cnt = 0;
  int rise_base;
  logic rdy_prev = 1'b0;
  logic [23:0] exp_cmd_q[$];
  logic        exp_tx_q[$];

  uart_cmd_slave #(.BAUD_DIV(16), .TIMEOUT(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Command monitor: every cmd_rdy rise pops one expected command
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (cmd_rdy && !rdy_prev) begin
        rise_cnt++;
        if (exp_cmd_q.size() == 0) check_val("cmd_unexpected", 32'(cmd), 32'hFFFFFFFF);
        else                       check_val("cmd", 32'(cmd), 32'(exp_cmd_q.pop_front()));
      end
      rdy_prev = cmd_rdy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    RX = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (16) @(negedge clk);
    end
    RX = stop_b;
    repeat (16) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    exp_cmd_q.push_back({c0, c1, c2});
    send_byte(c0, 1'b1);
    send_byte(c1, 1'b1);
    send_byte(c2, 1'b1);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check_val("clr_next_clk", 32'(cmd_rdy), 32'd0);
  endtask

  initial begin
    logic [9:0] fr;
    logic cur;
    cur = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(TX), 32'd1);
    check_val("rst_cmd", 32'(cmd), 32'd0);
    check_val("rst_rdy", 32'(cmd_rdy), 32'd0);
    check_val("rst_busy", 32'(tx_busy), 32'd0);
    check_val("rst_sent", 32'(resp_sent), 32'd0);
    check_val("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: basic command
    send_cmd(8'h02, 8'h1A, 8'h00);
    check_val("c1_rdy", 32'(cmd_rdy), 32'd1);
    check_val("c1_rises", 32'(rise_cnt), 32'd1);
    check_val("c1_no_ferr", 32'(fe_cnt), 32'd0);

    // 2: clear, then completion coinciding with clr_cmd_rdy
    clear_rdy();
    fork
      send_cmd(8'h03, 8'h80, 8'h00);
      begin
        repeat (448) @(negedge clk);
        for (int k = 0; k < 80; k++) begin
          clr_cmd_rdy = !cmd_rdy;
          if (cmd_rdy) break;
          @(negedge clk);
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check_val("c2_set_wins", 32'(cmd_rdy), 32'd1);
    check_val("c2_cmd", 32'(cmd), 32'h038000);
    check_val("c2_rises", 32'(rise_cnt), 32'd2);

    // 3: response A5, second send_resp mid-frame and one on resp_sent are ignored
    resp = 8'hA5;
    fr = {1'b1, resp, 1'b0};
    for (int b = 0; b < 10; b++) exp_tx_q.push_back(fr[b]);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i == 40) begin resp = 8'h3C; send_resp = 1'b1; end
      if (i == 41) send_resp = 1'b0;
      if ((i % 16) == 0) begin
        if (exp_tx_q.size() != 0) cur = exp_tx_q.pop_front();
        else cur = 1'b1;
      end
      check_val("tx_bit", 32'(TX), 32'(cur));
      check_val("tx_busy", 32'(tx_busy), 32'd1);
      check_val("resp_sent", 32'(resp_sent), (i == 159) ? 32'd1 : 32'd0);
      if (i == 159) send_resp = 1'b1;
      @(negedge clk);
    end
    send_resp = 1'b0;
    check_val("tx_busy_end", 32'(tx_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check_val("tx_idle_after", 32'({TX, tx_busy, resp_sent}), 32'b100);
      @(negedge clk);
    end

    // 4: framing error on byte1 drops the partial command
    clear_rdy();
    rise_base = rise_cnt;
    send_byte(8'h0B, 1'b1);
    send_byte(8'h22, 1'b0);
    check_val("c4_ferr", 32'(fe_cnt), 32'd1);
    check_val("c4_no_rdy", 32'(cmd_rdy), 32'd0);
    send_cmd(8'h08, 8'h12, 8'h34);
    check_val("c4_cmd", 32'(cmd), 32'h081234);
    check_val("c4_rises", 32'(rise_cnt - rise_base), 32'd1);

    // 5: inter-byte timeout discards a partial command
    clear_rdy();
    rise_base = rise_cnt;
    send_byte(8'h05, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (1100) @(negedge clk);
    send_cmd(8'h09, 8'h12, 8'h00);
    check_val("c5_cmd", 32'(cmd), 32'h091200);
    check_val("c5_rises", 32'(rise_cnt - rise_base), 32'd1);
    check_val("c5_ferr", 32'(fe_cnt), 32'd1);

    // 6: reset mid RX byte and mid TX frame
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (30) @(negedge clk);
        resp = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (40) @(negedge clk);
        check_val("c6_busy_pre", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("c6_tx", 32'(TX), 32'd1);
        check_val("c6_rdy", 32'(cmd_rdy), 32'd0);
        check_val("c6_busy", 32'(tx_busy), 32'd0);
        check_val("c6_cmd", 32'(cmd), 32'd0);
        repeat (20) @(negedge clk);
        check_val("c6_tx_quiet", 32'({TX, tx_busy}), 32'b10);
      end
    join
    rise_base = rise_cnt;
    send_cmd(8'h07, 8'h00, 8'h00);
    check_val("c6_cmd_after", 32'(cmd), 32'h070000);
    check_val("c6_rises", 32'(rise_cnt - rise_base), 32'd1);
    check_val("sb_empty", 32'(exp_cmd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
